spi_master_fifo: RTL and testbench
==================================

Name: spi_master_fifo

Overview:
- Parametrised SPI master with a memory-mapped register port, TX/RX FIFOs, a runtime clock divider and runtime mode selection (CPOL, CPHA, bit order).
- Replaces the fixed-width, single-buffer, fixed-rate SPI master in the QSYS peripheral set.
- Sits between the CPU bus and up to NUM_SS external SPI slaves.

Parameters:
- DATA_W, 16: frame width in bits; must be at least 16, because register fields use the low 16 bits.
- NUM_SS, 4: number of slave-select lines.
- FIFO_DEPTH, 8: entries per FIFO; must be a power of 2, at least 2.
- DIV_W, 8: width of the divider register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- addr  in  3  register address
- wr_en  in  1  single-cycle write strobe
- rd_en  in  1  single-cycle read strobe
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, registered
- irq  out  1  interrupt, registered, level
- sclk  out  1  SPI clock
- mosi  out  1  master data out
- miso  in  1  master data in
- ss_n  out  NUM_SS  active-low slave selects

Behaviour:
- Clocking and reset: clock is clk; reset is reset_n, asynchronous, active-low.
- Reset values:
  - Outputs: rdata=0, irq=0, sclk=0, mosi=0, ss_n=all 1.
  - Registers: CONTROL=0, DIV=0, SSEL=1.
  - State: both FIFOs empty, TOE=ROE=0, FSM=IDLE.
- Register map (bit 0 is the LSB):
  - 0 RXDATA, read: pops the RX FIFO.
  - 1 TXDATA, write: pushes the TX FIFO.
  - 2 STATUS, read: [0]TMT, [1]TXNF, [2]RXNE, [3]TOE, [4]ROE, [5]BUSY. Any write clears TOE and ROE.
  - 3 CONTROL, read/write: [0]CPOL, [1]CPHA, [2]LSBFIRST, [3]SSO, [4]IE_RXNE, [5]IE_TMT, [6]IE_ERR.
  - 4 DIV, read/write: half-period of sclk = DIV+1 clk cycles.
  - 5 SSEL, read/write: NUM_SS-bit mask; a 1 drives the matching ss_n low while selected.
  - 6–7: reads return 0; writes are ignored.
- Read latency: rdata is valid 1 cycle after rd_en.
- RXDATA read:
  - RX non-empty: returns the head word and pops it.
  - RX empty: returns 0, no pop.
- TXDATA write:
  - TX full and no same-cycle engine pop: word dropped, TOE set.
  - TX full with a same-cycle engine pop: push accepted.
- Error bits: a set event and a STATUS write in the same cycle leave the bit set (set wins).
- Status definitions:
  - TMT = TX empty & FSM==IDLE.
  - TXNF = TX not full.
  - RXNE = RX not empty.
  - BUSY = FSM!=IDLE.
- irq is registered and asserts 1 cycle after its condition: (IE_RXNE&RXNE) | (IE_TMT&TMT) | (IE_ERR&(TOE|ROE)).
- Divider: counter 0..DIV produces a tick when it reaches DIV, then wraps to 0; the counter is held at 0 in IDLE.
- FSM:
  - IDLE → SETUP when TX is non-empty. On this transition: pop TX into the shifter, latch CPOL/CPHA/LSBFIRST/DIV/SSEL, drive ss_n low per mask, and for CPHA=0 present the first bit on mosi.
  - SETUP → XFER after 1 tick.
  - XFER: each tick toggles sclk and increments the edge count 0..2*DATA_W-1.
    - Even edge counts are leading edges; odd edge counts are trailing edges.
    - CPHA=0: sample miso on leading edges, shift mosi on trailing edges.
    - CPHA=1: shift mosi on leading edges (including the first bit), sample miso on trailing edges.
    - After the last edge, sclk equals CPOL. Go to HOLD and push the RX word in the same cycle.
  - HOLD → IDLE after 1 tick.
- ss_n:
  - Deasserts on IDLE entry unless SSO=1.
  - With SSO=1, ss_n follows SSEL continuously, including in IDLE.
- sclk idles at the live CPOL value in IDLE. Config writes made while BUSY take effect at the next frame.
- Bit order: LSBFIRST=0 sends/receives the MSB first; LSBFIRST=1 sends/receives the LSB first. Received bits land in matching order.
- RX full at frame end: new word dropped, ROE set.
- Back-to-back frames: TX non-empty in IDLE starts the next frame on the next cycle, with one IDLE cycle between frames.
- Reset mid-frame: everything returns immediately to reset values, with no partial RX push.

Decomposition:
- Package spi_master_pkg holds:
  - register address constants;
  - STATUS/CONTROL bit index constants;
  - FSM state enum {IDLE, SETUP, XFER, HOLD}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice (TX and RX):
  - push/pop/full/empty;
  - simultaneous push and pop are both honoured, including when full or empty with a pop.

Test Plan:
- Reset → ss_n=4'b1111, sclk=0, mosi=0, irq=0; STATUS reads 0x0003.
- CPOL=0, CPHA=0, DIV=1, SSEL=0001, miso looped to mosi; write 0xA5C3 → ss_n[0] low; 32 sclk edges with a 4-clk period; RXDATA=0xA5C3; RXNE=1 before the read, 0 after.
- CPOL=1, CPHA=1, LSBFIRST=1, miso tied 1; write 0x0001 → sclk idles high; mosi=1 on the first leading edge then 0; RX=0xFFFF.
- DIV=7; write 10 words back-to-back → 1 in the shifter, 8 in TX, 10th dropped; TOE=1; with IE_ERR=1, irq high 1 cycle later; STATUS write clears TOE and irq.
- 9 frames with no RX reads → RX holds the first 8 words in order; ROE=1; 9th dropped.
- Assert reset_n at edge 10 of a frame → ss_n=all 1 and sclk=0 immediately; after release STATUS=0x0003 and RXNE=0.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master: register addresses, STATUS/CONTROL bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_pkg;

  // Register addresses
  localparam logic [2:0] A_RXDATA  = 3'd0;
  localparam logic [2:0] A_TXDATA  = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_CONTROL = 3'd3;
  localparam logic [2:0] A_DIV     = 3'd4;
  localparam logic [2:0] A_SSEL    = 3'd5;

  // STATUS bit positions
  localparam int ST_TMT   = 0;
  localparam int ST_TXNF  = 1;
  localparam int ST_RXNE  = 2;
  localparam int ST_TOE   = 3;
  localparam int ST_ROE   = 4;
  localparam int ST_BUSY  = 5;
  localparam int STATUS_W = 6;

  // CONTROL bit positions
  localparam int CT_CPOL    = 0;
  localparam int CT_CPHA    = 1;
  localparam int CT_LSB     = 2;
  localparam int CT_SSO     = 3;
  localparam int CT_IE_RXNE = 4;
  localparam int CT_IE_TMT  = 5;
  localparam int CT_IE_ERR  = 6;
  localparam int CTRL_W     = 7;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is visible combinationally while not empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, reset_n, push/push_data (write side), pop/head (read side), full, empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with register port, TX/RX FIFOs, runtime divider and CPOL/CPHA/bit-order selection.
// Latency: rdata and irq are registered (1 cycle); a queued TX word starts a frame the next cycle from IDLE.
// Backpressure: TX write to a full FIFO is dropped (TOE); RX word at frame end into a full FIFO is dropped (ROE).
// Ports: clk, reset_n; bus addr/wr_en/rd_en/wdata/rdata; irq; SPI sclk/mosi/miso/ss_n.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int EW = $clog2(2*DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W-1);

  logic [CTRL_W-1:0]   ctrl;
  logic [DIV_W-1:0]    div, div_l, dcnt;
  logic [NUM_SS-1:0]   ssel;
  logic                toe, roe;
  state_t              state;
  logic [DATA_W-1:0]   tx_sh, rx_sh, rx_in, rx_word, tx_head, rx_head;
  logic [EW-1:0]       ecnt;
  logic                cpha_l, lsb_l;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic                tick, lead_edge, wr_status, tmt;
  logic [STATUS_W-1:0] status;
  logic                unused_bits;

  assign unused_bits = &{1'b0, wdata};

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign tick      = (state != IDLE) && (dcnt == div_l);
  assign lead_edge = !ecnt[0];
  assign tx_push   = wr_en && (addr == A_TXDATA);
  assign tx_pop    = (state == IDLE) && !tx_empty;
  assign rx_pop    = rd_en && (addr == A_RXDATA) && !rx_empty;
  assign rx_push   = (state == XFER) && tick && (ecnt == LAST_EDGE);
  assign wr_status = wr_en && (addr == A_STATUS);
  assign tmt       = tx_empty && (state == IDLE);
  assign rx_in     = lsb_l ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
  // CPHA=1 samples on the final (trailing) edge, so that bit must be folded into the pushed word.
  assign rx_word   = cpha_l ? rx_in : rx_sh;

  always_comb begin
    status           = '0;
    status[ST_TMT]   = tmt;
    status[ST_TXNF]  = !tx_full;
    status[ST_RXNE]  = !rx_empty;
    status[ST_TOE]   = toe;
    status[ST_ROE]   = roe;
    status[ST_BUSY]  = (state != IDLE);
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .push_data(wdata),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .push_data(rx_word),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Register file, error flags, read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl  <= '0;
      div   <= '0;
      ssel  <= NUM_SS'(1);
      toe   <= 1'b0;
      roe   <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          A_CONTROL: ctrl <= wdata[CTRL_W-1:0];
          A_DIV:     div  <= wdata[DIV_W-1:0];
          A_SSEL:    ssel <= wdata[NUM_SS-1:0];
          default: ;
        endcase
      end
      // Set events win over a same-cycle STATUS write.
      toe <= (tx_push && tx_full && !tx_pop) || (toe && !wr_status);
      roe <= (rx_push && rx_full && !rx_pop) || (roe && !wr_status);
      if (rd_en) begin
        case (addr)
          A_RXDATA:  rdata <= rx_empty ? '0 : rx_head;
          A_STATUS:  rdata <= DATA_W'(status);
          A_CONTROL: rdata <= DATA_W'(ctrl);
          A_DIV:     rdata <= DATA_W'(div);
          A_SSEL:    rdata <= DATA_W'(ssel);
          default:   rdata <= '0;
        endcase
      end
      irq <= (ctrl[CT_IE_RXNE] && !rx_empty) || (ctrl[CT_IE_TMT] && tmt) ||
             (ctrl[CT_IE_ERR] && (toe || roe));
    end
  end

  // Frame engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      tx_sh  <= '0;
      rx_sh  <= '0;
      ecnt   <= '0;
      dcnt   <= '0;
      div_l  <= '0;
      cpha_l <= 1'b0;
      lsb_l  <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      ss_n   <= '1;
    end else begin
      dcnt <= (state == IDLE || tick) ? '0 : dcnt + 1'b1;
      case (state)
        IDLE: begin
          sclk <= ctrl[CT_CPOL];
          ss_n <= ctrl[CT_SSO] ? ~ssel : '1;
          if (!tx_empty) begin
            state  <= SETUP;
            cpha_l <= ctrl[CT_CPHA];
            lsb_l  <= ctrl[CT_LSB];
            div_l  <= div;
            ss_n   <= ~ssel;
            ecnt   <= '0;
            rx_sh  <= '0;
            // CPHA=0 needs the first bit on the wire before the first sampling edge.
            if (!ctrl[CT_CPHA]) begin
              mosi  <= ctrl[CT_LSB] ? tx_head[0] : tx_head[DATA_W-1];
              tx_sh <= shift_out(tx_head, ctrl[CT_LSB]);
            end else begin
              tx_sh <= tx_head;
            end
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER: if (tick) begin
          sclk <= ~sclk;
          ecnt <= ecnt + 1'b1;
          // Shift edge is leading for CPHA=1, trailing for CPHA=0; the other edge samples.
          if (lead_edge == cpha_l) begin
            mosi  <= lsb_l ? tx_sh[0] : tx_sh[DATA_W-1];
            tx_sh <= shift_out(tx_sh, lsb_l);
          end else begin
            rx_sh <= rx_in;
          end
          if (ecnt == LAST_EDGE) begin
            state <= HOLD;
            ecnt  <= '0;
          end
        end
        HOLD: if (tick) begin
          state <= IDLE;
          ss_n  <= ctrl[CT_SSO] ? ~ssel : '1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo with an expected-RX scoreboard queue.
// Latency: bus accesses take one cycle; frames are observed at the pins.
// Backpressure: exercises TX overflow (TOE) and RX overflow (ROE).
module tb_spi_master_fifo;
  import spi_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  addr;
  logic        wr_en, rd_en;
  logic [15:0] wdata, rdata;
  logic        irq, sclk, mosi, miso;
  logic [3:0]  ss_n;

  logic        loop_en, miso_val;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic        mo[32];

  assign miso = loop_en ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master_fifo #(.DATA_W(16), .NUM_SS(4), .FIFO_DEPTH(8), .DIV_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .irq(irq), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic rx_check(input string tag);
    logic [15:0] d, e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
    rd(A_RXDATA, d);
    check(tag, 32'(d), 32'(e));
  endtask

  // Follows one frame from ss_n low until ss_n returns high, logging mosi after each sclk edge.
  task automatic watch_frame(output int edges, output int gap);
    logic prev, seen_low, done;
    int   last;
    edges = 0; gap = 0; last = 0; prev = sclk; seen_low = 1'b0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (sclk !== prev) begin
        if (edges < 32) mo[edges] = mosi;
        if (edges == 1) gap = c - last;
        last = c; edges++; prev = sclk;
      end
      if (ss_n !== 4'hF) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    check("frame_done", 32'(done), 32'd1);
  endtask

  task automatic wait_tmt();
    logic [15:0] s;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      rd(A_STATUS, s);
      ok = s[ST_TMT];
    end
    check("wait_tmt", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [15:0] d, w;
    int          edges, gap;
    logic        prev;

    reset_n = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    loop_en = 1'b0; miso_val = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_irq",  32'(irq),  32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rd(A_STATUS, d);  check("rst_status", 32'(d), 32'h0003);
    rd(A_CONTROL, d); check("rst_control", 32'(d), 32'h0000);
    rd(A_DIV, d);     check("rst_div", 32'(d), 32'h0000);
    rd(A_SSEL, d);    check("rst_ssel", 32'(d), 32'h0001);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, d);      check("reg6_zero", 32'(d), 32'h0000);

    // Mode 0, MSB first, loopback
    loop_en = 1'b1;
    wr(A_CONTROL, 16'h0000); wr(A_DIV, 16'd1); wr(A_SSEL, 16'h0001);
    wr(A_TXDATA, 16'hA5C3); exp_q.push_back(16'hA5C3);
    @(negedge clk);
    check("m0_ss_n", 32'(ss_n), 32'hE);
    watch_frame(edges, gap);
    check("m0_edges", 32'(edges), 32'd32);
    check("m0_halfper", 32'(gap), 32'd2);
    check("m0_sclk_end", 32'(sclk), 32'd0);
    rd(A_STATUS, d);  check("m0_status_rxne", 32'(d), 32'h0007);
    rx_check("m0_rx");
    rd(A_STATUS, d);  check("m0_status_after", 32'(d), 32'h0003);

    // CPOL=1, CPHA=1, LSB first, miso tied high
    loop_en = 1'b0; miso_val = 1'b1;
    wr(A_CONTROL, 16'h0007);
    @(negedge clk);
    check("m3_sclk_idle", 32'(sclk), 32'd1);
    wr(A_TXDATA, 16'h0001); exp_q.push_back(16'hFFFF);
    watch_frame(edges, gap);
    check("m3_edges", 32'(edges), 32'd32);
    check("m3_mosi_lead0", 32'(mo[0]), 32'd1);
    check("m3_mosi_lead1", 32'(mo[2]), 32'd0);
    check("m3_sclk_end", 32'(sclk), 32'd1);
    rx_check("m3_rx");

    // TX overflow: 10 back-to-back writes with a slow divider
    loop_en = 1'b1;
    wr(A_CONTROL, 16'h0040); wr(A_DIV, 16'd7);
    @(negedge clk);
    addr = A_TXDATA; wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = 16'h3C5A + 16'(i) * 16'h1F07;
      wdata = w;
      if (i < 9) exp_q.push_back(w);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("toe_irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    check("toe_irq", 32'(irq), 32'd1);
    rd(A_STATUS, d);  check("toe_status", 32'(d), 32'h0028);
    wr(A_STATUS, 16'h0000);
    @(negedge clk);
    check("toe_irq_cleared", 32'(irq), 32'd0);
    rd(A_STATUS, d);  check("toe_cleared", 32'(d[ST_TOE]), 32'd0);

    // Nine frames with no RX reads: the ninth overflows RX
    wait_tmt();
    rd(A_STATUS, d);  check("roe_status", 32'(d), 32'h0017);
    check("roe_irq", 32'(irq), 32'd1);
    void'(exp_q.pop_back());
    for (int i = 0; i < 8; i++) rx_check($sformatf("rx_order%0d", i));
    rx_check("rx_empty_read");
    rd(A_STATUS, d);  check("roe_drained", 32'(d), 32'h0013);
    wr(A_STATUS, 16'h0000);

    // Reset in the middle of a frame
    wr(A_CONTROL, 16'h0000); wr(A_DIV, 16'd1);
    wr(A_TXDATA, 16'h1234);
    edges = 0; prev = sclk;
    for (int c = 0; c < 400 && edges < 11; c++) begin
      @(negedge clk);
      if (sclk !== prev) begin edges++; prev = sclk; end
    end
    check("mid_edge10", 32'(edges), 32'd11);
    check("mid_sclk_pre", 32'(sclk), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 32'(ss_n), 32'hF);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(A_STATUS, d);  check("mid_status", 32'(d), 32'h0003);
    rd(A_RXDATA, d);  check("mid_rx_empty", 32'(d), 32'h0000);
    check("mid_irq", 32'(irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
